// File: rtl/msi_pkg.sv
// Shared types for the MSI home directory: directory and L1 state codes,
// hit/miss verdict codes, writeback codes and controller FSM states.
package msi_pkg;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_S = 2'd1,
        DIR_M = 2'd2
    } dir_state_e;

    localparam logic [1:0] L1_I = 2'b01;
    localparam logic [1:0] L1_S = 2'b10;
    localparam logic [1:0] L1_M = 2'b11;

    localparam logic [1:0] HOM_HIT  = 2'b01;
    localparam logic [1:0] HOM_MISS = 2'b00;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_DONE = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_INVAL  = 3'd2,
        ST_FETCH  = 3'd3,
        ST_RESP   = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/msi_dir_array.sv
// Directory storage: per-address state, sharer vector, owner and backing memory.
// One combinational read port and one synchronous write port share the address.
module msi_dir_array
    import msi_pkg::*;
#(
    parameter int NUM_PROC = 2,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int PROC_W   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output dir_state_e          rd_state_o,
    output logic [NUM_PROC-1:0] rd_sharers_o,
    output logic [PROC_W-1:0]   rd_owner_o,
    output logic [DATA_W-1:0]   rd_data_o,
    input  logic                dir_we_i,
    input  dir_state_e          wr_state_i,
    input  logic [NUM_PROC-1:0] wr_sharers_i,
    input  logic [PROC_W-1:0]   wr_owner_i,
    input  logic                mem_we_i,
    input  logic [DATA_W-1:0]   wr_data_i
);
    localparam int DEPTH = 2**ADDR_W;

    dir_state_e          state_q   [DEPTH];
    logic [NUM_PROC-1:0] sharers_q [DEPTH];
    logic [PROC_W-1:0]   owner_q   [DEPTH];
    logic [DATA_W-1:0]   mem_q     [DEPTH];

    assign rd_state_o   = state_q[addr_i];
    assign rd_sharers_o = sharers_q[addr_i];
    assign rd_owner_o   = owner_q[addr_i];
    assign rd_data_o    = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Memory powers up holding its own (truncated) address as data.
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i]   <= DIR_U;
                sharers_q[i] <= '0;
                owner_q[i]   <= '0;
                mem_q[i]     <= DATA_W'(i);
            end
        end else begin
            if (dir_we_i) begin
                state_q[addr_i]   <= wr_state_i;
                sharers_q[addr_i] <= wr_sharers_i;
                owner_q[addr_i]   <= wr_owner_i;
            end
            if (mem_we_i) begin
                mem_q[addr_i] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/msi_directory_ctrl.sv
// MSI home-node directory controller: looks up the directory, invalidates sharers or
// fetches from the owner, then responds. Optional counters under MSI_DIR_STATS_EN.
module msi_directory_ctrl
    import msi_pkg::*;
#(
    parameter int NUM_PROC = 2,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    localparam int PROC_W  = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [PROC_W-1:0]   req_proc_i,
    input  logic                req_write_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [1:0]          hit_or_miss_i,
    output logic                inv_valid_o,
    output logic [NUM_PROC-1:0] inv_mask_o,
    input  logic                inv_ack_i,
    output logic                fetch_valid_o,
    output logic [PROC_W-1:0]   fetch_proc_o,
    input  logic [DATA_W-1:0]   fetch_data_i,
    input  logic                fetch_ack_i,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_data_o,
    output logic [1:0]          resp_state_o,
    output logic [1:0]          write_back_o,
`ifdef MSI_DIR_STATS_EN
    output logic [15:0]         stat_miss_o,
    output logic [15:0]         stat_inv_o,
    output logic [15:0]         stat_wb_o,
`endif
    output fsm_state_e          state_o
);
    localparam bit PROC_POW2 = (2**PROC_W == NUM_PROC);

    fsm_state_e          state_q;
    logic [PROC_W-1:0]   proc_q, fetch_proc_q;
    logic                write_q, wb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          hit_q;
    logic                req_ready_q, inv_valid_q, fetch_valid_q, resp_valid_q;
    logic [NUM_PROC-1:0] inv_mask_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [1:0]          resp_state_q, write_back_q;

    dir_state_e          rd_state, wr_state, eff_state;
    logic [NUM_PROC-1:0] rd_sharers, wr_sharers, req_bit, own_bit, others;
    logic [PROC_W-1:0]   rd_owner, wr_owner;
    logic [DATA_W-1:0]   rd_data;
    logic                dir_we, mem_we, is_hit, foreign_m, proc_ok;

    assign proc_ok = PROC_POW2 || (int'(req_proc_i) < NUM_PROC);
    assign is_hit  = (hit_q == HOM_HIT);

    msi_dir_array #(
        .NUM_PROC(NUM_PROC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROC_W(PROC_W)
    ) u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .addr_i      (addr_q),
        .rd_state_o  (rd_state),
        .rd_sharers_o(rd_sharers),
        .rd_owner_o  (rd_owner),
        .rd_data_o   (rd_data),
        .dir_we_i    (dir_we),
        .wr_state_i  (wr_state),
        .wr_sharers_i(wr_sharers),
        .wr_owner_i  (wr_owner),
        .mem_we_i    (mem_we),
        .wr_data_i   (fetch_data_i)
    );

    always_comb begin
        req_bit = '0;
        req_bit[proc_q] = 1'b1;
        own_bit = '0;
        own_bit[fetch_proc_q] = 1'b1;
        // An M entry owned by the requester that now misses lost its copy silently.
        eff_state = (rd_state == DIR_M && rd_owner == proc_q && !is_hit) ? DIR_U : rd_state;
        foreign_m = (eff_state == DIR_M) && (rd_owner != proc_q);
        others    = rd_sharers & ~req_bit;
        dir_we     = 1'b0;
        mem_we     = 1'b0;
        wr_state   = rd_state;
        wr_sharers = rd_sharers;
        wr_owner   = rd_owner;
        case (state_q)
            ST_LOOKUP: begin
                if (!write_q) begin
                    if (!is_hit && !foreign_m) begin
                        dir_we     = 1'b1;
                        wr_state   = DIR_S;
                        wr_sharers = rd_sharers | req_bit;
                    end
                end else if (!foreign_m && !(eff_state == DIR_S && others != '0)) begin
                    dir_we     = 1'b1;
                    wr_state   = DIR_M;
                    wr_sharers = req_bit;
                    wr_owner   = proc_q;
                end
            end
            ST_INVAL: begin
                if (inv_ack_i) begin
                    dir_we     = 1'b1;
                    wr_state   = DIR_M;
                    wr_sharers = req_bit;
                    wr_owner   = proc_q;
                end
            end
            ST_FETCH: begin
                if (fetch_ack_i) begin
                    mem_we = 1'b1;
                    if (!write_q) begin
                        dir_we     = 1'b1;
                        wr_state   = DIR_S;
                        wr_sharers = own_bit | req_bit;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef MSI_DIR_STATS_EN
    logic [15:0] stat_miss_q, stat_inv_q, stat_wb_q;
    logic        inv_seen_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            proc_q        <= '0;
            fetch_proc_q  <= '0;
            write_q       <= 1'b0;
            wb_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            hit_q         <= '0;
            inv_valid_q   <= 1'b0;
            inv_mask_q    <= '0;
            fetch_valid_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_state_q  <= '0;
            write_back_q  <= WB_NONE;
`ifdef MSI_DIR_STATS_EN
            stat_miss_q   <= '0;
            stat_inv_q    <= '0;
            stat_wb_q     <= '0;
            inv_seen_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && proc_ok) begin
                        proc_q      <= req_proc_i;
                        write_q     <= req_write_i;
                        addr_q      <= req_addr_i;
                        data_q      <= req_data_i;
                        hit_q       <= hit_or_miss_i;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (foreign_m && (write_q || !is_hit)) begin
                        fetch_valid_q <= 1'b1;
                        fetch_proc_q  <= rd_owner;
                        state_q       <= ST_FETCH;
                    end else if (write_q && eff_state == DIR_S && others != '0) begin
                        inv_valid_q <= 1'b1;
                        inv_mask_q  <= others;
`ifdef MSI_DIR_STATS_EN
                        inv_seen_q  <= 1'b1;
`endif
                        state_q     <= ST_INVAL;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= write_q ? data_q : rd_data;
                        resp_state_q <= (write_q || (is_hit && rd_state == DIR_M && rd_owner == proc_q))
                                        ? L1_M : L1_S;
                        state_q      <= ST_RESP;
                    end
                end
                ST_INVAL: begin
                    if (inv_ack_i) begin
                        inv_valid_q  <= 1'b0;
                        inv_mask_q   <= '0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= data_q;
                        resp_state_q <= L1_M;
                        write_back_q <= wb_q ? WB_DONE : WB_NONE;
                        state_q      <= ST_RESP;
                    end
                end
                ST_FETCH: begin
                    if (fetch_ack_i) begin
                        fetch_valid_q <= 1'b0;
                        wb_q          <= 1'b1;
                        if (!write_q) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= fetch_data_i;
                            resp_state_q <= L1_S;
                            write_back_q <= WB_DONE;
                            state_q      <= ST_RESP;
                        end else begin
                            inv_valid_q <= 1'b1;
                            inv_mask_q  <= own_bit;
`ifdef MSI_DIR_STATS_EN
                            inv_seen_q  <= 1'b1;
`endif
                            state_q     <= ST_INVAL;
                        end
                    end
                end
                ST_RESP: begin
`ifdef MSI_DIR_STATS_EN
                    if (hit_q == HOM_MISS && stat_miss_q != 16'hFFFF) stat_miss_q <= stat_miss_q + 16'd1;
                    if (inv_seen_q && stat_inv_q != 16'hFFFF) stat_inv_q <= stat_inv_q + 16'd1;
                    if (wb_q && stat_wb_q != 16'hFFFF) stat_wb_q <= stat_wb_q + 16'd1;
                    inv_seen_q <= 1'b0;
`endif
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= '0;
                    resp_state_q <= '0;
                    write_back_q <= WB_NONE;
                    wb_q         <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign inv_valid_o   = inv_valid_q;
    assign inv_mask_o    = inv_mask_q;
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_proc_o  = fetch_proc_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_data_o   = resp_data_q;
    assign resp_state_o  = resp_state_q;
    assign write_back_o  = write_back_q;
    assign state_o       = state_q;
`ifdef MSI_DIR_STATS_EN
    assign stat_miss_o   = stat_miss_q;
    assign stat_inv_o    = stat_inv_q;
    assign stat_wb_o     = stat_wb_q;
`endif

endmodule

// File: tb/tb_msi_directory_ctrl.sv
// Randomized self-checking bench for msi_directory_ctrl against a behavioural
// directory model (state/sharers/owner/memory arrays updated per transaction).
module tb_msi_directory_ctrl;
  import msi_pkg::*;

  localparam int NP = 2;
  localparam int AW = 4;
  localparam int DW = 4;

  // valid/ready: a request transfers on a rising edge where req_valid_i and req_ready_o
  // are both high; inv/fetch valids stay high until their ack is sampled on an edge.
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_proc = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [1:0]    hom = 2'b00;
  logic          inv_valid;
  logic [NP-1:0] inv_mask;
  logic          inv_ack = 1'b0;
  logic          fetch_valid;
  logic          fetch_proc;
  logic [DW-1:0] fetch_data = '0;
  logic          fetch_ack = 1'b0;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic [1:0]    resp_state;
  logic [1:0]    write_back;
  fsm_state_e    dut_state;
`ifdef MSI_DIR_STATS_EN
  logic [15:0]   stat_miss, stat_inv, stat_wb;
`endif

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  msi_directory_ctrl #(.NUM_PROC(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_proc_i(req_proc),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .hit_or_miss_i(hom),
    .inv_valid_o(inv_valid), .inv_mask_o(inv_mask), .inv_ack_i(inv_ack),
    .fetch_valid_o(fetch_valid), .fetch_proc_o(fetch_proc),
    .fetch_data_i(fetch_data), .fetch_ack_i(fetch_ack),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_state_o(resp_state),
    .write_back_o(write_back),
`ifdef MSI_DIR_STATS_EN
    .stat_miss_o(stat_miss), .stat_inv_o(stat_inv), .stat_wb_o(stat_wb),
`endif
    .state_o(dut_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_mis = 0;
  logic [DW-1:0] exp_q[$];

  // reference model: 0 = uncached, 1 = shared, 2 = modified
  int         m_st  [16];
  logic [1:0] m_sh  [16];
  int         m_own [16];
  logic [3:0] m_mem [16];
  logic [3:0] l1_data [2][16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_st[i] = 0;
      m_sh[i] = 2'b00;
      m_own[i] = 0;
      m_mem[i] = 4'(i);
      l1_data[0][i] = 4'h0;
      l1_data[1][i] = 4'h0;
    end
  endtask

  task automatic model_txn(input int p, input bit wr, input int a, input logic [3:0] d,
                           input logic [1:0] v, input logic [3:0] fd,
                           output bit e_fetch, output int e_fproc, output bit e_inv,
                           output logic [1:0] e_imask, output logic [3:0] e_data,
                           output logic [1:0] e_state, output bit e_wb);
    bit hit;
    int st;
    logic [1:0] rb;
    hit = (v == HOM_HIT);
    rb = 2'(1 << p);
    st = m_st[a];
    if (st == 2 && m_own[a] == p && !hit) st = 0;
    e_fetch = 0; e_fproc = 0; e_inv = 0; e_imask = 2'b00; e_wb = 0;
    if (!wr) begin
      if (hit) begin
        e_data = m_mem[a];
        e_state = (m_st[a] == 2 && m_own[a] == p) ? L1_M : L1_S;
      end else if (st != 2) begin
        m_sh[a] = m_sh[a] | rb;
        m_st[a] = 1;
        e_data = m_mem[a];
        e_state = L1_S;
      end else begin
        e_fetch = 1;
        e_fproc = m_own[a];
        e_wb = 1;
        m_mem[a] = fd;
        m_sh[a] = 2'(1 << m_own[a]) | rb;
        m_st[a] = 1;
        e_data = fd;
        e_state = L1_S;
      end
    end else begin
      if (st == 2 && m_own[a] != p) begin
        e_fetch = 1;
        e_fproc = m_own[a];
        e_wb = 1;
        m_mem[a] = fd;
        e_inv = 1;
        e_imask = 2'(1 << m_own[a]);
      end else if (st == 1 && (m_sh[a] & ~rb) != 2'b00) begin
        e_inv = 1;
        e_imask = m_sh[a] & ~rb;
      end
      m_st[a] = 2;
      m_own[a] = p;
      m_sh[a] = rb;
      l1_data[p][a] = d;
      e_data = d;
      e_state = L1_M;
    end
  endtask

  // driver: one full transaction with handshake responses and response checks
  task automatic run_txn(input int p, input bit wr, input int a, input logic [3:0] d,
                         input logic [1:0] v, input int force_dly);
    bit e_fetch, e_inv, e_wb, done, had_inv, had_fetch;
    int e_fproc, lat, exp_lat, inv_n, fetch_n, inv_dly, fetch_dly, w;
    logic [1:0] e_imask, e_state;
    logic [3:0] e_data, fd;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("req_ready_wait", req_ready, 1'b1);
    fd = l1_data[m_own[a]][a];
    model_txn(p, wr, a, d, v, fd, e_fetch, e_fproc, e_inv, e_imask, e_data, e_state, e_wb);
    exp_q.push_back(e_data);
    req_valid = 1'b1;
    req_proc = p[0];
    req_write = wr;
    req_addr = 4'(a);
    req_data = d;
    hom = v;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; exp_lat = 2; done = 0; had_inv = 0; had_fetch = 0;
    inv_n = 0; fetch_n = 0; inv_dly = 0; fetch_dly = 0;
    while (!done && lat < 40) begin
      if (inv_valid) begin
        if (inv_n == 0) begin
          had_inv = 1;
          inv_dly = (force_dly >= 0) ? force_dly : $urandom_range(0, 3);
          exp_lat += 1 + inv_dly;
          check_eq("inv_mask", inv_mask, e_imask);
        end
        inv_ack = (inv_n == inv_dly);
        inv_n++;
      end else begin
        inv_ack = 1'b0;
      end
      if (fetch_valid) begin
        if (fetch_n == 0) begin
          had_fetch = 1;
          fetch_dly = $urandom_range(0, 3);
          exp_lat += 1 + fetch_dly;
          check_eq("fetch_proc", fetch_proc, e_fproc[0]);
        end
        fetch_ack = (fetch_n == fetch_dly);
        fetch_data = (fetch_n == fetch_dly) ? fd : 4'h0;
        fetch_n++;
      end else begin
        fetch_ack = 1'b0;
        fetch_data = 4'h0;
      end
      if (resp_valid) begin
        done = 1;
        check_eq("resp_data", resp_data, exp_q.pop_front());
        check_eq("resp_state", resp_state, e_state);
        check_eq("write_back", write_back, e_wb ? WB_DONE : WB_NONE);
        check_eq("resp_latency", lat, exp_lat);
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    inv_ack = 1'b0;
    fetch_ack = 1'b0;
    if (!done) begin
      check_eq("resp_timeout", 1'b0, 1'b1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check_eq("inv_activity", had_inv, e_inv);
    check_eq("fetch_activity", had_fetch, e_fetch);
    @(negedge clk);
    check_eq("resp_one_cycle", resp_valid, 1'b0);
  endtask

  initial begin
    int p, a, w;
    bit wr, hold;
    logic [3:0] d;
    logic [1:0] v;

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_inv_valid", inv_valid, 1'b0);
    check_eq("rst_fetch_valid", fetch_valid, 1'b0);
    check_eq("rst_write_back", write_back, 2'b00);
    check_eq("rst_state", dut_state, ST_IDLE);

    // directed sequence from the coherence scenarios
    run_txn(0, 0, 7, 4'h0, HOM_MISS, -1);
    run_txn(1, 1, 7, 4'h6, HOM_MISS, 3);
    run_txn(0, 0, 7, 4'h0, HOM_MISS, -1);
    run_txn(1, 0, 7, 4'h0, HOM_HIT, -1);
    run_txn(0, 1, 4, 4'hA, HOM_MISS, -1);
    run_txn(1, 1, 4, 4'h3, HOM_MISS, -1);
    run_txn(0, 0, 4, 4'h0, HOM_MISS, -1);

    // reset while an invalidation is outstanding
    run_txn(0, 0, 9, 4'h0, HOM_MISS, -1);
    req_valid = 1'b1; req_proc = 1'b1; req_write = 1'b1; req_addr = 4'h9;
    req_data = 4'h5; hom = HOM_MISS;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!inv_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_eq("mid_inv_valid", inv_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("mid_rst_state", dut_state, ST_IDLE);
    check_eq("mid_rst_inv_valid", inv_valid, 1'b0);
    check_eq("mid_rst_ready", req_ready, 1'b1);
    check_eq("mid_rst_resp_valid", resp_valid, 1'b0);
    run_txn(1, 1, 9, 4'h5, HOM_MISS, -1);
    run_txn(0, 0, 7, 4'h0, HOM_MISS, -1);

    // randomized traffic concentrated on a few lines
    for (int n = 0; n < 250; n++) begin
      p = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      d = 4'($urandom);
      if (!wr) hold = (m_st[a] != 0) && m_sh[a][p];
      else hold = (m_st[a] == 2) && (m_own[a] == p);
      v = hold ? HOM_HIT : HOM_MISS;
      if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 1) ? HOM_HIT : HOM_MISS;
      run_txn(p, wr, a, d, v, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/msi_directory_ctrl.md
Name: msi_directory_ctrl

Overview:
- Home-node directory controller for the MSI directory protocol.
- Sits directly downstream of the per-processor L1 cache models. It consumes each cache's request (address, read/write, data) together with that cache's hit/miss verdict.
- It tracks per-address directory state, sharer set and backing memory. It issues invalidations and owner fetches, then returns data plus the granted state to the requester.

Parameters:
- NUM_PROC, 2, number of L1 caches tracked (sharer vector width)
- ADDR_W, 4, address width; directory depth is 2**ADDR_W entries
- DATA_W, 4, data word width

Ports:
- Clock  input  1  single system clock; all logic on posedge
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  controller idle, can accept
- ReqProc  input  $clog2(NUM_PROC)  requesting processor index
- ReqWrite  input  1  1 = write, 0 = read
- ReqAddr  input  ADDR_W  request address
- ReqData  input  DATA_W  write data
- HitOrMiss  input  2  requester L1 verdict: 2'b01 hit, 2'b00 miss
- InvValid  output  1  invalidate request to caches
- InvMask  output  NUM_PROC  caches to invalidate
- InvAck  input  1  all masked caches invalidated
- FetchValid  output  1  fetch/downgrade request to owner
- FetchProc  output  $clog2(NUM_PROC)  owner index
- FetchData  input  DATA_W  dirty data from owner
- FetchAck  input  1  FetchData valid
- RespValid  output  1  one-cycle response pulse
- RespData  output  DATA_W  data returned to requester
- RespState  output  2  granted L1 state: 01 I, 10 S, 11 M
- WriteBack  output  2  2'b01 for the response cycle of a transaction that wrote owner data to memory, else 2'b00

Behaviour:
- Reset (synchronous, active-high, also mid-transaction):
  - FSM returns to IDLE.
  - Every directory entry becomes Uncached (U) with sharers = 0 and owner = 0.
  - mem[a] = a[DATA_W-1:0].
  - All outputs go to 0, except ReqReady = 1 in the cycle after reset deasserts.
  - Outstanding Inv/Fetch handshakes are abandoned.
- FSM states: IDLE, LOOKUP, INVAL, FETCH, RESP.
- IDLE:
  - ReqReady = 1.
  - On ReqValid, latch the request and go to LOOKUP.
  - ReqProc >= NUM_PROC is dropped with no response.
- LOOKUP (one cycle) reads the entry and decides the path:
  - Read, hit: go to RESP. No directory change. RespState = S, or M if the requester is the owner.
  - Read, miss, entry U or S: sharers |= req, state S, go to RESP.
  - Read, miss, entry M with owner != req: go to FETCH.
  - Write with no other sharers and no foreign owner: state M, owner = req, sharers = req, go to RESP.
  - Write with entry S and other sharers: go to INVAL with InvMask = sharers & ~req.
  - Write with entry M and owner != req: go to FETCH, then INVAL of the owner.
  - Entry M with owner == req but HitOrMiss = miss: treated as Uncached; memory data is used, no fetch.
- INVAL:
  - InvValid held high until InvAck is sampled high.
  - Then sharers = req, owner = req, state M, go to RESP.
- FETCH:
  - FetchValid held high until FetchAck.
  - On the FetchAck cycle: mem[addr] <= FetchData and a WriteBack flag is set.
  - Read path: state S, sharers = owner | req, go to RESP.
  - Write path: go to INVAL with InvMask = owner bit.
- RESP (one cycle):
  - RespValid = 1.
  - Reads: RespData = mem[addr] after any writeback.
  - Writes: RespData = ReqData. Memory is not updated; the line is dirty in the owner.
  - Next state IDLE.
- Latency:
  - Request accepted at edge N gives RespValid in cycle N+2 when no coherence traffic is needed.
  - Each INVAL/FETCH adds 1 + handshake wait cycles.
- Handshake rules:
  - InvAck/FetchAck are ignored outside their states.
  - Ack arriving in the same cycle as Valid rises counts; the minimum INVAL/FETCH dwell is 1 cycle.
- Address wrap: none. Indices are exactly ADDR_W bits.

Optional Feature:
- Macro: MSI_DIR_STATS_EN.
- When defined, adds three 16-bit saturating output counters:
  - StatMiss: requests with HitOrMiss = 00.
  - StatInv: INVAL entries.
  - StatWb: writebacks.
- Counters clear on Reset and increment in the RESP cycle.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package msi_pkg holds:
  - dir state enum (U/S/M);
  - L1 state constants (I = 2'b01, S = 2'b10, M = 2'b11);
  - HitOrMiss codes HIT = 2'b01, MISS = 2'b00;
  - WriteBack codes;
  - FSM state enum.
- One natural sub-module: msi_dir_array. It holds the directory state/sharer/owner/memory storage, with one combinational read port and one synchronous write port.

Test Plan:
- After reset: P0 read miss addr 4'h7 -> RespValid at N+2, RespData = 4'h7, RespState = S, entry S with sharers = 2'b01, WriteBack = 00.
- Then P1 write miss addr 4'h7 -> InvValid with InvMask = 2'b01; InvAck after 3 cycles -> RespState = M, RespData = ReqData 4'h6, entry M with owner P1.
- Then P0 read miss addr 4'h7 -> FetchValid with FetchProc = 1; FetchAck with FetchData = 4'h6 -> RespData = 4'h6, WriteBack = 01, entry S with sharers = 2'b11, mem[7] = 4'h6.
- P1 write miss addr 4'h4 while P0 holds it M -> FETCH then INVAL of P0 -> mem[4] updated, RespState = M, owner P1.
- Assert Reset during INVAL wait -> next cycle IDLE, InvValid = 0, ReqReady = 1, all entries U.
- Read hit by an S sharer -> RespValid at N+2, no Inv/Fetch activity, directory unchanged.
